square_channel_gen: RTL and testbench

Parametrised square-wave sound channel covering both GBC pulse channels (sweep channel 1 and plain channel 2). It contains its own 512 Hz frame sequencer, length counter, volume envelope, frequency timer and duty sequencer. It takes decoded register writes from the sound register front-end and drives a digital amplitude sample to the sound mixer.

---
 rtl/square_channel_gen.sv | 184 ++++++++++++++++++
 tb/tb_square_channel_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/square_channel_gen.sv
// square_channel_gen: GBC pulse channel with its own frame sequencer, length, envelope, timer and duty.
// Define SQUARE_SWEEP_EN to build channel 1 (frequency sweep on NRx0); undefined builds channel 2.
module square_channel_gen #(
    parameter int CLKS_PER_512HZ = 64453,
    parameter int TIMER_PRESCALE = 32,
    parameter int LEN_W          = 6,
    parameter int VOL_W          = 4
) (
    input  logic             I_CLK_33MHZ,
    input  logic             I_RESET,
    input  logic [2:0]       I_REG_SEL,
    input  logic [7:0]       I_REG_DATA,
    input  logic             I_REG_WE,
    output logic [VOL_W-1:0] O_SAMPLE,
    output logic             O_ENABLED,
    output logic [2:0]       O_FRAME_STEP
);
    localparam int DIV_W = $clog2(CLKS_PER_512HZ + 1);
    localparam int PRE_W = $clog2(TIMER_PRESCALE + 1);
    localparam logic [LEN_W:0] LEN_MAX = {1'b1, {LEN_W{1'b0}}};
    localparam logic [VOL_W-1:0] VOL_MAX = '1;

    logic [DIV_W-1:0] div;
    logic [2:0]       step_nxt;
    logic             frame_tick, len_tick, env_tick;
    logic [PRE_W-1:0] pre;
    logic             pre_pulse;
    logic [1:0]       duty;
    logic [LEN_W:0]   len_cnt;
    logic             len_en, len_dec;
    logic [3:0]       init_vol;
    logic             env_up;
    logic [2:0]       env_period, env_cnt;
    logic             dac_en;
    logic [10:0]      freq, freq_new;
    logic [11:0]      timer;
    logic [2:0]       pos;
    logic [VOL_W-1:0] vol;
    logic [7:0]       duty_pat;
    logic             duty_bit;
    logic             wr_nr1, wr_nr2, wr_nr3, wr_nr4, trigger;

    assign frame_tick = div == DIV_W'(CLKS_PER_512HZ - 1);
    assign step_nxt   = O_FRAME_STEP + 3'd1;
    assign len_tick   = frame_tick & ~step_nxt[0];
    assign env_tick   = frame_tick & (step_nxt == 3'd7);
    assign pre_pulse  = pre == PRE_W'(TIMER_PRESCALE - 1);

    assign wr_nr1   = I_REG_WE & (I_REG_SEL == 3'd1);
    assign wr_nr2   = I_REG_WE & (I_REG_SEL == 3'd2);
    assign wr_nr3   = I_REG_WE & (I_REG_SEL == 3'd3);
    assign wr_nr4   = I_REG_WE & (I_REG_SEL == 3'd4);
    assign trigger  = wr_nr4 & I_REG_DATA[7];
    assign freq_new = {I_REG_DATA[2:0], freq[7:0]};
    // a register write or trigger owns the length counter in its cycle
    assign len_dec  = len_tick & len_en & (len_cnt != '0) & ~wr_nr1 & ~trigger;

    always_comb begin
        duty_pat = duty == 2'd0 ? 8'b00000001 :
                   duty == 2'd1 ? 8'b10000001 :
                   duty == 2'd2 ? 8'b10000111 : 8'b01111110;
        duty_bit = duty_pat[3'd7 - pos];
    end

`ifdef SQUARE_SWEEP_EN
    logic [2:0]  sweep_period, shift;
    logic        negate;
    logic [10:0] shadow;
    logic [3:0]  sweep_cnt, sweep_reload;
    logic [11:0] calc_tick, calc_trig;
    logic        wr_nr0, sweep_tick;

    function automatic logic [11:0] sweep_calc(input logic [10:0] base, input logic neg, input logic [2:0] sh);
        logic [11:0] d;
        d = {1'b0, base >> sh};
        return neg ? {1'b0, base} - d : {1'b0, base} + d;
    endfunction

    assign wr_nr0       = I_REG_WE & (I_REG_SEL == 3'd0);
    assign sweep_tick   = frame_tick & (step_nxt[1:0] == 2'b10);
    assign sweep_reload = sweep_period == 3'd0 ? 4'd8 : {1'b0, sweep_period};
    assign calc_tick    = sweep_calc(shadow, negate, shift);
    assign calc_trig    = sweep_calc(freq_new, negate, shift);
`endif

    always_ff @(posedge I_CLK_33MHZ) begin
        if (I_RESET) begin
            div          <= '0;
            O_FRAME_STEP <= '0;
            pre          <= '0;
        end else begin
            div          <= frame_tick ? '0 : div + 1'b1;
            O_FRAME_STEP <= frame_tick ? step_nxt : O_FRAME_STEP;
            pre          <= pre_pulse ? '0 : pre + 1'b1;
        end
    end

    always_ff @(posedge I_CLK_33MHZ) begin
        if (I_RESET) begin
            duty       <= '0;
            len_cnt    <= '0;
            len_en     <= 1'b0;
            init_vol   <= '0;
            env_up     <= 1'b0;
            env_period <= '0;
            env_cnt    <= '0;
            dac_en     <= 1'b0;
            freq       <= '0;
            timer      <= '0;
            pos        <= '0;
            vol        <= '0;
            O_ENABLED  <= 1'b0;
            O_SAMPLE   <= '0;
`ifdef SQUARE_SWEEP_EN
            sweep_period <= '0;
            negate       <= 1'b0;
            shift        <= '0;
            shadow       <= '0;
            sweep_cnt    <= '0;
`endif
        end else begin
            if (pre_pulse) begin
                timer <= timer <= 12'd1 ? 12'd2048 - {1'b0, freq} : timer - 12'd1;
                pos   <= timer <= 12'd1 ? pos + 3'd1 : pos;
            end
            if (len_dec) begin
                len_cnt <= len_cnt - 1'b1;
                if (len_cnt == 1) O_ENABLED <= 1'b0;
            end
            if (env_tick && env_period != 3'd0) begin
                env_cnt <= env_cnt <= 3'd1 ? env_period : env_cnt - 3'd1;
                if (env_cnt <= 3'd1 && env_up && vol != VOL_MAX) vol <= vol + 1'b1;
                if (env_cnt <= 3'd1 && !env_up && vol != '0) vol <= vol - 1'b1;
            end
`ifdef SQUARE_SWEEP_EN
            if (sweep_tick) begin
                sweep_cnt <= sweep_cnt <= 4'd1 ? sweep_reload : sweep_cnt - 4'd1;
                if (sweep_cnt <= 4'd1 && sweep_period != 3'd0) begin
                    if (calc_tick[11]) O_ENABLED <= 1'b0;
                    else if (shift != 3'd0) begin
                        shadow <= calc_tick[10:0];
                        freq   <= calc_tick[10:0];
                    end
                end
            end
            if (wr_nr0) begin
                sweep_period <= I_REG_DATA[6:4];
                negate       <= I_REG_DATA[3];
                shift        <= I_REG_DATA[2:0];
            end
`endif
            if (wr_nr1) begin
                duty    <= I_REG_DATA[7:6];
                len_cnt <= LEN_MAX - {1'b0, I_REG_DATA[LEN_W-1:0]};
            end
            if (wr_nr2) begin
                init_vol   <= I_REG_DATA[7:4];
                env_up     <= I_REG_DATA[3];
                env_period <= I_REG_DATA[2:0];
                dac_en     <= |I_REG_DATA[7:3];
                if (I_REG_DATA[7:3] == 5'd0) O_ENABLED <= 1'b0;
            end
            if (wr_nr3) freq[7:0] <= I_REG_DATA;
            if (wr_nr4) begin
                freq[10:8] <= I_REG_DATA[2:0];
                len_en     <= I_REG_DATA[6];
            end
            if (trigger) begin
                O_ENABLED <= dac_en;
                if (len_cnt == '0) len_cnt <= len_tick && I_REG_DATA[6] ? LEN_MAX - 1'b1 : LEN_MAX;
                timer   <= 12'd2048 - {1'b0, freq_new};
                pos     <= '0;
                vol     <= VOL_W'(init_vol);
                env_cnt <= env_period;
`ifdef SQUARE_SWEEP_EN
                shadow    <= freq_new;
                sweep_cnt <= sweep_reload;
                if (shift != 3'd0 && calc_trig[11]) O_ENABLED <= 1'b0;
`endif
            end
            O_SAMPLE <= O_ENABLED && duty_bit ? vol : '0;
        end
    end
endmodule

// File: tb/tb_square_channel_gen.sv
// tb_square_channel_gen: directed scoreboard bench for square_channel_gen with a shortened frame/timer rate.
module tb_square_channel_gen;
    localparam int CLKS = 40;
    localparam int PRE  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sel = '0;
    logic [7:0] data = '0;
    logic       we = 1'b0;
    logic [3:0] sample;
    logic       enabled;
    logic [2:0] step;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    square_channel_gen #(.CLKS_PER_512HZ(CLKS), .TIMER_PRESCALE(PRE), .LEN_W(6), .VOL_W(4)) dut (
        .I_CLK_33MHZ(clk), .I_RESET(rst), .I_REG_SEL(sel), .I_REG_DATA(data), .I_REG_WE(we),
        .O_SAMPLE(sample), .O_ENABLED(enabled), .O_FRAME_STEP(step)
    );

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check(input logic [31:0] obs);
        logic [31:0] e;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0d, no expectation queued", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", t, obs, e);
        end
    endtask

    task automatic wr(input logic [2:0] s, input logic [7:0] d);
        sel = s;
        data = d;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    // waits for the frame step to change to s (or to any even step when even=1)
    task automatic wait_step(input string tag, input logic [2:0] s, input bit even);
        logic [2:0] prev;
        bit ok;
        prev = step;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (step != prev && (even ? !step[0] : step == s)) ok = 1'b1;
            prev = step;
        end
        push_exp(tag, 1);
        check(32'(ok));
    endtask

    task automatic peak(output int m);
        m = 0;
        @(negedge clk);
        repeat (32) begin
            @(negedge clk);
            if (int'(sample) > m) m = int'(sample);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pat;
        int m, n;
        logic [31:0] env_seq [4];
        env_seq = '{2, 1, 0, 0};
        pat = 8'b10000111;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push_exp("rst_sample", 0);  check(32'(sample));
        push_exp("rst_enabled", 0); check(32'(enabled));
        push_exp("rst_step", 0);    check(32'(step));

        wr(2, 8'hF0); wr(1, 8'h80); wr(3, 8'h00); wr(4, 8'h87);
        push_exp("duty_trig_en", 1); check(32'(enabled));
        repeat (512) @(negedge clk);
        for (int p = 0; p < 8; p++) begin
            push_exp($sformatf("duty_pos%0d", p), pat[7-p] ? 15 : 0);
            check(32'(sample));
            repeat (256 * PRE) @(negedge clk);
        end

        wr(3, 8'hFF); wr(4, 8'h87);
        repeat (8) @(negedge clk);
        n = 0;
        repeat (32) begin
            @(negedge clk);
            if (sample != 0) n++;
        end
        push_exp("freq2047_high_count", 16); check(32'(n));

        wr(1, 8'h3E); wr(4, 8'hC7);
        push_exp("len_trig_en", 1); check(32'(enabled));
        wait_step("len_wait1", 0, 1);
        push_exp("len_after_tick1", 1); check(32'(enabled));
        wait_step("len_wait2", 0, 1);
        push_exp("len_after_tick2", 0); check(32'(enabled));
        @(negedge clk);
        push_exp("len_sample_off", 0); check(32'(sample));
        wait_step("len_wait3", 0, 1);
        push_exp("len_no_wrap", 0); check(32'(enabled));
        wr(4, 8'hC7);
        wait_step("len_wait4", 0, 1);
        push_exp("len_retrigger", 1); check(32'(enabled));

        wr(2, 8'h31); wr(1, 8'hC0); wr(3, 8'hFF);
        wait_step("env_sync", 0, 0);
        wr(4, 8'h87);
        peak(m);
        push_exp("env_vol_init", 3); check(32'(m));
        for (int k = 0; k < 4; k++) begin
            wait_step($sformatf("env_wait%0d", k), 7, 0);
            peak(m);
            push_exp($sformatf("env_vol_step%0d", k), env_seq[k]); check(32'(m));
        end

        push_exp("dac_playing", 1); check(32'(enabled));
        wr(2, 8'h00);
        push_exp("dac_off", 0); check(32'(enabled));
        wr(4, 8'h87);
        push_exp("dac_off_trigger", 0); check(32'(enabled));

        wr(2, 8'hF0); wr(4, 8'h87);
        push_exp("midnote_en", 1); check(32'(enabled));
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_exp("midrst_sample", 0);  check(32'(sample));
        push_exp("midrst_enabled", 0); check(32'(enabled));
        push_exp("midrst_step", 0);    check(32'(step));
        rst = 1'b0;
        repeat (4) @(negedge clk);
        push_exp("postrst_sample", 0); check(32'(sample));

`ifdef SQUARE_SWEEP_EN
        wr(2, 8'hF0); wr(0, 8'h11); wr(3, 8'h00); wr(4, 8'h87);
        push_exp("sweep_overflow", 0); check(32'(enabled));
        wr(0, 8'h19); wr(4, 8'h87);
        push_exp("sweep_negate_ok", 1); check(32'(enabled));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
